drec_sequencer: RTL

//  Parametrised successor to the recorder control path: multi-slot record/playback sequencer.

---
 rtl/drec_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/drec_sequencer.sv
// drec_sequencer: multi-slot record/playback sequencer between button
// decode, ADC/DAC paths and the SDRAM request/response FIFOs.
module drec_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 24,
  parameter int SLOT_BITS      = 2,
  parameter int SLOT_ADDR_BITS = 20,
  parameter int SAMPLE_DIV     = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play_btn,
  input  logic                  rec_btn,
  input  logic [SLOT_BITS-1:0]  slot_sel,
  input  logic                  loop_en,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic [DATA_WIDTH-1:0] dac_data,
  output logic                  dac_enable,
  output logic [ADDR_WIDTH-1:0] sdram_wr_addr,
  output logic [DATA_WIDTH-1:0] sdram_wr_data,
  output logic                  sdram_wr_enable,
  output logic [ADDR_WIDTH-1:0] sdram_rd_addr,
  output logic                  sdram_rd_enable,
  input  logic [DATA_WIDTH-1:0] sdram_rd_data,
  input  logic                  sdram_rd_data_rdy,
  output logic                  sdram_rd_data_ack,
  output logic                  btn_rst,
  output logic [1:0]            state,
  output logic                  underrun
);

  localparam int NSLOT = 1 << SLOT_BITS;
  localparam int LW    = SLOT_ADDR_BITS + 1;
  localparam int CW    = $clog2(SAMPLE_DIV);
  localparam logic [LW-1:0] FULL = LW'(1) << SLOT_ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_PLAY = 2'd2
  } st_t;

  st_t                  st;
  logic [CW-1:0]        div;
  logic                 tick;
  logic                 btn;
  logic                 pop;
  logic                 pending;
  logic [SLOT_BITS-1:0] slot;
  logic [LW-1:0]        wptr;
  logic [LW-1:0]        rptr;
  logic [LW-1:0]        len [NSLOT];

  assign tick  = (div == CW'(SAMPLE_DIV - 1));
  assign btn   = play_btn | rec_btn;
  // ack is forced low for a cycle between pops of a level-style FIFO flag
  assign pop   = sdram_rd_data_rdy & ~sdram_rd_data_ack;
  assign state = st;

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(
    input logic [SLOT_BITS-1:0] s,
    input logic [LW-1:0]        p
  );
    return ADDR_WIDTH'({s, p[SLOT_ADDR_BITS-1:0]});
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st                <= S_IDLE;
      div               <= '0;
      pending           <= 1'b0;
      slot              <= '0;
      wptr              <= '0;
      rptr              <= '0;
      dac_data          <= '0;
      dac_enable        <= 1'b0;
      sdram_wr_addr     <= '0;
      sdram_wr_data     <= '0;
      sdram_wr_enable   <= 1'b0;
      sdram_rd_addr     <= '0;
      sdram_rd_enable   <= 1'b0;
      sdram_rd_data_ack <= 1'b0;
      btn_rst           <= 1'b0;
      underrun          <= 1'b0;
      for (int i = 0; i < NSLOT; i++) len[i] <= '0;
    end else begin
      div               <= tick ? '0 : div + CW'(1);
      sdram_wr_enable   <= 1'b0;
      sdram_rd_enable   <= 1'b0;
      dac_enable        <= 1'b0;
      btn_rst           <= 1'b0;
      sdram_rd_data_ack <= pop;
      if (pop) begin
        pending <= 1'b0;
        if (pending && st == S_PLAY) begin
          dac_data   <= sdram_rd_data;
          dac_enable <= 1'b1;
        end
      end
      unique case (st)
        S_IDLE: begin
          if (rec_btn) begin
            st            <= S_REC;
            slot          <= slot_sel;
            wptr          <= '0;
            len[slot_sel] <= '0;
          end else if (play_btn && len[slot_sel] != '0) begin
            st       <= S_PLAY;
            slot     <= slot_sel;
            rptr     <= '0;
            underrun <= 1'b0;
          end
        end
        S_REC: begin
          if (btn) begin
            len[slot] <= wptr;
            st        <= S_IDLE;
            btn_rst   <= 1'b1;
          end else if (tick) begin
            sdram_wr_enable <= 1'b1;
            sdram_wr_addr   <= slot_addr(slot, wptr);
            sdram_wr_data   <= adc_data;
            wptr            <= wptr + LW'(1);
            if (wptr == FULL - LW'(1)) begin
              len[slot] <= FULL;
              st        <= S_IDLE;
              btn_rst   <= 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (btn) begin
            st      <= S_IDLE;
            btn_rst <= 1'b1;
          end else if (tick) begin
            if (pending) begin
              underrun <= 1'b1;
            end else if (rptr == len[slot]) begin
              if (loop_en) begin
                sdram_rd_enable <= 1'b1;
                sdram_rd_addr   <= slot_addr(slot, '0);
                pending         <= 1'b1;
                rptr            <= LW'(1);
              end else begin
                st      <= S_IDLE;
                btn_rst <= 1'b1;
              end
            end else begin
              sdram_rd_enable <= 1'b1;
              sdram_rd_addr   <= slot_addr(slot, rptr);
              pending         <= 1'b1;
              rptr            <= rptr + LW'(1);
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
